// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression engine: one round per clock over a 16-word schedule window.
// Define SHA256_FINAL_ADD_EN to fold the feed-forward addition (H + a..h) into hash_out.
module sha256_round_ctrl #(
  parameter int BIT_W  = 32,
  parameter int ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [16*BIT_W-1:0]  block_in,
  input  logic [8*BIT_W-1:0]   hash_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [8*BIT_W-1:0]   hash_out,
  output logic [5:0]           round
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_q, state_d;
  logic        load;
  logic        last_round;
  logic [31:0] w [0:15];
  logic [31:0] s [0:7];
  logic [31:0] nxt [0:7];
  logic [31:0] t1, t2, w_new;
  logic [8*BIT_W-1:0] result;
`ifdef SHA256_FINAL_ADD_EN
  logic [31:0] hv [0:7];
`endif

  assign last_round = (round == 6'(ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (last_round) state_d = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Round function and schedule expansion; s[0] is a, s[7] is h.
  always_comb begin
    t1     = s[7] + big_sigma1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + K[round] + w[0];
    t2     = big_sigma0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    nxt[0] = t1 + t2;
    nxt[1] = s[0];
    nxt[2] = s[1];
    nxt[3] = s[2];
    nxt[4] = s[3] + t1;
    nxt[5] = s[4];
    nxt[6] = s[5];
    nxt[7] = s[6];
    w_new  = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    result = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef SHA256_FINAL_ADD_EN
      result[255-32*i -: 32] = nxt[i] + hv[i];
`else
      result[255-32*i -: 32] = nxt[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        s[i] <= '0;
`ifdef SHA256_FINAL_ADD_EN
        hv[i] <= '0;
`endif
      end
      round    <= '0;
      hash_out <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
      for (int i = 0; i < 8; i++) begin
        s[i] <= hash_in[255-32*i -: 32];
`ifdef SHA256_FINAL_ADD_EN
        hv[i] <= hash_in[255-32*i -: 32];
`endif
      end
      round <= '0;
    end else if (state_q == ROUND) begin
      for (int i = 0; i < 8; i++) s[i] <= nxt[i];
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      if (last_round) hash_out <= result;
      else            round    <= round + 6'd1;
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: directed FIPS 180-4 vectors, latency and control checks.
// Follows SHA256_FINAL_ADD_EN to choose between digest and raw a..h expectations.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] hash_in = '0;
  logic         ready, busy, done;
  logic [255:0] hash_out;
  logic [5:0]   round;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  typedef struct {
    logic [255:0] hash;
    int           cyc;
    string        name;
  } exp_t;
  exp_t sb[$];

`ifdef SHA256_FINAL_ADD_EN
  localparam bit FINAL_ADD = 1'b1;
`else
  localparam bit FINAL_ADD = 1'b0;
`endif

  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_NUL = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_2BL = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_NUL = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_2B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_round_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .block_in (block_in),
    .hash_in  (hash_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out),
    .round    (round)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] addw(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  function automatic logic [255:0] subw(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] - y[32*i +: 32];
    return r;
  endfunction

  // Textbook compression with a full 64-word schedule; returns a..h before feed-forward.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  function automatic logic [255:0] expect_digest(input logic [255:0] digest, input logic [255:0] hin);
    return FINAL_ADD ? digest : subw(digest, hin);
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive a request before a rising edge; the scoreboard entry records the acceptance edge.
  task automatic applyStimulus(input string name, input logic [511:0] blk, input logic [255:0] hin,
                               input logic [255:0] req);
    exp_t e;
    start    = 1'b1;
    block_in = blk;
    hash_in  = hin;
    @(posedge clk);
    #1;
    e.hash = req;
    e.cyc  = cyc;
    e.name = name;
    sb.push_back(e);
    start    = 1'b0;
    block_in = '0;
    hash_in  = '0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput({name, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic waitRound(input string name, input logic [5:0] r);
    int n = 0;
    while (round != r && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (round != r) checkOutput({name, "_round_timeout"}, 256'(round), 256'(r));
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput({e.name, "_hash"}, hash_out, e.hash);
        checkOutput({e.name, "_latency"}, 256'(cyc - e.cyc), 256'(64));
        checkOutput({e.name, "_ready_busy"}, 256'({ready, busy}), 256'(2'b10));
      end
    end
  end

  initial begin
    logic [255:0] h1;
    logic [255:0] raw1;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 256'(ready), 256'(1));
    checkOutput("reset_busy", 256'(busy), 256'(0));
    checkOutput("reset_done", 256'(done), 256'(0));
    checkOutput("reset_round", 256'(round), 256'(0));
    checkOutput("reset_hash", hash_out, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("abc", BLK_ABC, IV, expect_digest(DIG_ABC, IV));
    checkOutput("abc_busy", 256'({ready, busy}), 256'(2'b01));
    waitDone("abc");
    @(negedge clk);
    checkOutput("idle_after_done", 256'({ready, busy, done}), 256'(3'b100));

    applyStimulus("empty", BLK_NUL, IV, expect_digest(DIG_NUL, IV));
    waitDone("empty");
    @(negedge clk);

    raw1 = compress(IV, BLK_2B1);
    h1   = addw(raw1, IV);
    applyStimulus("blk1", BLK_2B1, IV, FINAL_ADD ? h1 : raw1);
    waitDone("blk1");
    checkOutput("b2b_ready", 256'(ready), 256'(1));
    applyStimulus("blk2", BLK_2B2, h1, expect_digest(DIG_2BL, h1));
    checkOutput("b2b_accept", 256'({busy, round}), 256'({1'b1, 6'd0}));
    waitDone("blk2");
    @(negedge clk);

    applyStimulus("abc_ign", BLK_ABC, IV, expect_digest(DIG_ABC, IV));
    waitRound("abc_ign", 6'd10);
    start    = 1'b1;
    block_in = BLK_NUL;
    hash_in  = '0;
    @(negedge clk);
    start    = 1'b0;
    block_in = '0;
    checkOutput("ignored_start_round", 256'({busy, round}), 256'({1'b1, 6'd11}));
    waitDone("abc_ign");
    @(negedge clk);

    applyStimulus("abc_rst_aborted", BLK_ABC, IV, expect_digest(DIG_ABC, IV));
    waitRound("abc_rst", 6'd30);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_flags", 256'({ready, busy, done}), 256'(3'b100));
    checkOutput("midreset_round", 256'(round), 256'(0));
    checkOutput("midreset_hash", hash_out, 256'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", 256'({ready, busy, done}), 256'(3'b100));
    applyStimulus("abc_after_rst", BLK_ABC, IV, expect_digest(DIG_ABC, IV));
    waitDone("abc_after_rst");
    repeat (3) @(negedge clk);

    checkOutput("scoreboard_drain", 256'(sb.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
